// File: rtl/div_issue_unit_if.sv
// div_issue_unit_if: divider op type plus the EXU, divider and writeback handshakes of the issue unit
package riscv_div_pkg;
  typedef enum logic [1:0] {DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU} riscv_div_op_e;
endpackage

interface div_issue_unit_if import riscv_div_pkg::*; #(parameter int TAG_W = 5);
  logic up_valid, up_ready, flush;
  riscv_div_op_e up_opcode, div_req_opcode;
  logic [31:0] up_dataA, up_dataB, div_req_dataA, div_req_dataB, div_resp_data, wb_data;
  logic [TAG_W-1:0] up_tag, wb_tag;
  logic div_req_valid, div_req_ready, div_resp_valid, div_resp_ready, wb_valid, wb_ready;
  modport slave (
    input up_valid, up_opcode, up_dataA, up_dataB, up_tag, flush,
          div_req_ready, div_resp_valid, div_resp_data, wb_ready,
    output up_ready, div_req_valid, div_req_opcode, div_req_dataA, div_req_dataB,
           div_resp_ready, wb_valid, wb_data, wb_tag
  );
  modport master (
    output up_valid, up_opcode, up_dataA, up_dataB, up_tag, flush,
           div_req_ready, div_resp_valid, div_resp_data, wb_ready,
    input up_ready, div_req_valid, div_req_opcode, div_req_dataA, div_req_dataB,
          div_resp_ready, wb_valid, wb_data, wb_tag
  );
endinterface

// File: rtl/div_issue_unit.sv
// div_issue_unit: issues DIV/REM ops to the iterative divider and returns tagged results, with a last-result cache
module div_issue_unit import riscv_div_pkg::*; #(
  parameter int TAG_W = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  div_issue_unit_if.slave io
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, OUT} state_e;
  state_e state, state_n;
  riscv_div_op_e op_q, c_op;
  logic [31:0] a_q, b_q, res_q, c_a, c_b, c_res;
  logic [TAG_W-1:0] tag_q;
  logic c_vld, take, hit, req_xfer, resp_done;
  assign take = state == IDLE && io.up_valid && !io.flush;
  assign hit = CACHE_EN && c_vld && io.up_opcode == c_op && io.up_dataA == c_a && io.up_dataB == c_b;
  assign req_xfer = io.div_req_valid && io.div_req_ready;
  assign resp_done = state == WAIT && io.div_resp_valid && !io.flush;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = take ? (hit ? OUT : ISSUE) : IDLE;
      ISSUE:   state_n = io.flush ? (req_xfer ? DRAIN : IDLE) : (req_xfer ? WAIT : ISSUE);
      // a response on the flush cycle is already consumed, so nothing is left to drain
      WAIT:    state_n = io.flush ? (io.div_resp_valid ? IDLE : DRAIN) : (io.div_resp_valid ? OUT : WAIT);
      DRAIN:   state_n = io.div_resp_valid ? IDLE : DRAIN;
      OUT:     state_n = (io.flush || io.wb_ready) ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= DIV_OP_DIV;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      res_q <= '0;
      c_op <= DIV_OP_DIV;
      c_a <= '0;
      c_b <= '0;
      c_res <= '0;
      c_vld <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        op_q <= io.up_opcode;
        a_q <= io.up_dataA;
        b_q <= io.up_dataB;
        tag_q <= io.up_tag;
        if (hit) res_q <= c_res;
      end
      if (resp_done) begin
        res_q <= io.div_resp_data;
        c_op <= op_q;
        c_a <= a_q;
        c_b <= b_q;
        c_res <= io.div_resp_data;
        c_vld <= CACHE_EN;
      end
    end
  end
  assign io.up_ready = state == IDLE;
  assign io.div_req_valid = state == ISSUE;
  assign io.div_req_opcode = op_q;
  assign io.div_req_dataA = a_q;
  assign io.div_req_dataB = b_q;
  assign io.div_resp_ready = state == WAIT || state == DRAIN;
  assign io.wb_valid = state == OUT;
  assign io.wb_data = res_q;
  assign io.wb_tag = tag_q;
endmodule

// File: tb/tb_div_issue_unit.sv
// tb_div_issue_unit: directed vectors against a behavioural divider, cached and uncached instances
module tb_div_issue_unit;
  import riscv_div_pkg::*;
  logic clk = 0, rst = 1;
  int vectors = 0, errors = 0, lat = 3;
  always #5 clk = ~clk;
  div_issue_unit_if #(.TAG_W(5)) io [2] ();

  function automatic logic [31:0] div_ref(riscv_div_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic ovf;
    sa = a;
    sb = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    sq = ovf ? sa : (b == 0 ? -1 : sa / sb);
    sr = ovf ? 0 : (b == 0 ? sa : sa % sb);
    case (op)
      DIV_OP_DIV:  return sq;
      DIV_OP_DIVU: return b == 0 ? 32'hFFFF_FFFF : a / b;
      DIV_OP_REM:  return sr;
      default:     return b == 0 ? a : a % b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : m
    int cnt = 0, req_cnt = 0, resp_cnt = 0;
    logic busy = 0;
    logic [31:0] res = 0, last_a = 0, last_b = 0;
    div_issue_unit #(.TAG_W(5), .CACHE_EN(g == 0)) u (.clk(clk), .rst(rst), .io(io[g]));
    assign io[g].div_req_ready = !busy && !io[g].div_resp_valid;
    always @(posedge clk) begin
      if (rst) begin
        busy <= 0;
        io[g].div_resp_valid <= 0;
        io[g].div_resp_data <= 0;
      end else begin
        if (io[g].div_req_valid && io[g].div_req_ready) begin
          busy <= 1;
          cnt <= lat;
          res <= div_ref(io[g].div_req_opcode, io[g].div_req_dataA, io[g].div_req_dataB);
          last_a <= io[g].div_req_dataA;
          last_b <= io[g].div_req_dataB;
          req_cnt <= req_cnt + 1;
        end else if (busy && cnt > 0) cnt <= cnt - 1;
        else if (busy) begin
          busy <= 0;
          io[g].div_resp_valid <= 1;
          io[g].div_resp_data <= res;
        end
        if (io[g].div_resp_valid && io[g].div_resp_ready) begin
          io[g].div_resp_valid <= 0;
          resp_cnt <= resp_cnt + 1;
        end
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(riscv_div_op_e op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    int n = 0;
    @(negedge clk);
    while (!io[0].up_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("up_ready_wait", io[0].up_ready, 1);
    io[0].up_opcode = op;
    io[0].up_dataA = a;
    io[0].up_dataB = b;
    io[0].up_tag = t;
    io[0].up_valid = 1;
    @(posedge clk);
    #1 io[0].up_valid = 0;
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    @(negedge clk);
    while (!io[0].wb_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, io[0].wb_valid, 1);
  endtask

  task automatic run(string name, riscv_div_op_e op, logic [31:0] a, logic [31:0] b,
                     logic [4:0] t, logic [31:0] exp, int reqs);
    int r0 = m[0].req_cnt;
    send(op, a, b, t);
    wait_valid(name);
    check({name, "_data"}, io[0].wb_data, exp);
    check({name, "_tag"}, {27'd0, io[0].wb_tag}, {27'd0, t});
    check({name, "_reqs"}, m[0].req_cnt - r0, reqs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, s0, n;
    logic seen;
    for (int k = 0; k < 1; k++) begin
      io[0].up_valid = 0; io[0].flush = 0; io[0].wb_ready = 1;
      io[0].up_opcode = DIV_OP_DIV; io[0].up_dataA = 0; io[0].up_dataB = 0; io[0].up_tag = 0;
      io[1].up_valid = 0; io[1].flush = 0; io[1].wb_ready = 1;
      io[1].up_opcode = DIV_OP_DIV; io[1].up_dataA = 0; io[1].up_dataB = 0; io[1].up_tag = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_up_ready", io[0].up_ready, 1);
    check("rst_wb_valid", io[0].wb_valid, 0);
    check("rst_req_valid", io[0].div_req_valid, 0);
    check("rst_resp_ready", io[0].div_resp_ready, 0);
    check("rst_wb_data", io[0].wb_data, 0);
    check("rst_wb_tag", {27'd0, io[0].wb_tag}, 0);
    rst = 0;
    run("div", DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFFA, 1);
    check("div_req_a", m[0].last_a, 32'd20);
    check("div_req_b", m[0].last_b, 32'hFFFF_FFFD);
    run("rem_miss", DIV_OP_REM, 32'd20, 32'hFFFF_FFFD, 5'd4, 32'h2, 1);
    r0 = m[0].req_cnt;
    send(DIV_OP_REM, 32'd20, 32'hFFFF_FFFD, 5'd7);
    @(negedge clk);
    check("hit_valid_1cyc", io[0].wb_valid, 1);
    check("hit_data", io[0].wb_data, 32'h2);
    check("hit_tag", {27'd0, io[0].wb_tag}, 32'd7);
    check("hit_no_req", io[0].div_req_valid, 0);
    check("hit_reqs", m[0].req_cnt - r0, 0);
    @(posedge clk);
    #1;
    run("divu_by0", DIV_OP_DIVU, 32'd7, 32'd0, 5'd1, 32'hFFFF_FFFF, 1);
    run("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, 1);
    io[0].wb_ready = 0;
    send(DIV_OP_DIVU, 32'd50, 32'd5, 5'd9);
    wait_valid("hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", io[0].wb_valid, 1);
      check("hold_data", io[0].wb_data, 32'd10);
      check("hold_tag", {27'd0, io[0].wb_tag}, 32'd9);
      check("hold_up_ready", io[0].up_ready, 0);
    end
    io[0].wb_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("release_up_ready", io[0].up_ready, 1);
    check("release_wb_valid", io[0].wb_valid, 0);
    run("after_hold", DIV_OP_DIVU, 32'd9, 32'd2, 5'd1, 32'd4, 1);
    @(negedge clk);
    io[0].up_valid = 1; io[0].flush = 1;
    @(posedge clk);
    #1 io[0].up_valid = 0; io[0].flush = 0;
    @(negedge clk);
    check("idle_flush_up_ready", io[0].up_ready, 1);
    check("idle_flush_req", io[0].div_req_valid, 0);
    lat = 10;
    s0 = m[0].resp_cnt;
    send(DIV_OP_REMU, 32'd13, 32'd5, 5'd2);
    n = 0;
    while (!io[0].div_resp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("flush_reach_wait", io[0].div_resp_ready, 1);
    repeat (4) @(negedge clk);
    io[0].flush = 1;
    @(posedge clk);
    #1 io[0].flush = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io[0].wb_valid) seen = 1;
    end
    check("flush_no_wb", seen, 0);
    check("flush_resp_drained", m[0].resp_cnt - s0, 1);
    check("flush_up_ready", io[0].up_ready, 1);
    lat = 3;
    run("remu_after_flush", DIV_OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 1);
    run("flushed_not_cached", DIV_OP_REMU, 32'd13, 32'd5, 5'd6, 32'd3, 1);
    lat = 10;
    send(DIV_OP_DIV, 32'd100, 32'd10, 5'd6);
    n = 0;
    while (!io[0].div_resp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstw_reach_wait", io[0].div_resp_ready, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("rstw_up_ready", io[0].up_ready, 1);
    check("rstw_wb_valid", io[0].wb_valid, 0);
    check("rstw_req_valid", io[0].div_req_valid, 0);
    rst = 0;
    lat = 3;
    run("rstw_cache_invalid", DIV_OP_REMU, 32'd13, 32'd5, 5'd3, 32'd3, 1);
    r0 = m[1].req_cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      io[1].up_opcode = DIV_OP_REM; io[1].up_dataA = 32'd20; io[1].up_dataB = 32'hFFFF_FFFD;
      io[1].up_tag = 5'd7; io[1].up_valid = 1;
      @(posedge clk);
      #1 io[1].up_valid = 0;
      n = 0;
      @(negedge clk);
      while (!io[1].wb_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("nocache_valid", io[1].wb_valid, 1);
      check("nocache_data", io[1].wb_data, 32'h2);
      @(posedge clk);
      #1;
    end
    check("nocache_reqs", m[1].req_cnt - r0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
